// File: rtl/cube_pkg.sv
// Shared types for the cube-table PLA evaluator: FSM states, default sizes
// and the cube-table entry record.
package cube_pkg;

   localparam int NIN_DEF   = 14;
   localparam int NCUBE_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic               en;
      logic [NIN_DEF-1:0] mask;
      logic [NIN_DEF-1:0] val;
   } cube_t;

endpackage

// File: rtl/cube_match.sv
// Combinational single-cube test: the entry hits when enabled and every
// cared-for literal agrees with the input vector.
module cube_match
   import cube_pkg::*;
#(
   parameter int NIN = NIN_DEF
) (
   input  logic           i_en,
   input  logic [NIN-1:0] i_mask,
   input  logic [NIN-1:0] i_val,
   input  logic [NIN-1:0] i_vec,
   output logic           o_hit
);

   assign o_hit = i_en && (((i_vec ^ i_val) & i_mask) == {NIN{1'b0}});

endmodule

// File: rtl/cube_eval_sched.sv
// Sequential PLA evaluator: walks the cube table one entry per cycle and
// reports the lowest matching entry through a valid/ready output stage.
module cube_eval_sched
   import cube_pkg::*;
#(
   parameter int NIN   = NIN_DEF,
   parameter int NCUBE = NCUBE_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [$clog2(NCUBE)-1:0] cfg_idx,
   input  logic                     cfg_en,
   input  logic [NIN-1:0]           cfg_mask,
   input  logic [NIN-1:0]           cfg_val,
   output logic                     cfg_ready,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIN-1:0]           in_vec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_y,
   output logic [$clog2(NCUBE)-1:0] out_idx
);

   localparam int IW = $clog2(NCUBE);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCUBE - 1);

   state_t            r_state;
   logic [NCUBE-1:0]  r_en;
   logic [NIN-1:0]    r_mask [NCUBE];
   logic [NIN-1:0]    r_val  [NCUBE];
   logic [NIN-1:0]    r_vec;
   logic [IW-1:0]     r_idx;
   logic              r_chk_vld;
   logic              r_chk_hit;
   logic [IW-1:0]     r_chk_idx;
   logic              r_rdy;
   logic              r_out_valid;
   logic              r_out_y;
   logic [IW-1:0]     r_out_idx;
   logic              w_hit;
   logic              w_cfg_wr;

   assign w_cfg_wr = cfg_we && (r_state == ST_IDLE);

   // Cube table storage; only writable while idle so a scan sees a frozen table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en <= '0;
         for (int k = 0; k < NCUBE; k++) begin
            r_mask[k] <= '0;
            r_val[k]  <= '0;
         end
      end else if (w_cfg_wr) begin
         r_en[cfg_idx]   <= cfg_en;
         r_mask[cfg_idx] <= cfg_mask;
         r_val[cfg_idx]  <= cfg_val;
      end
   end

   cube_match #(.NIN(NIN)) u_match (
      .i_en   (r_en[r_idx]),
      .i_mask (r_mask[r_idx]),
      .i_val  (r_val[r_idx]),
      .i_vec  (r_vec),
      .o_hit  (w_hit)
   );

   // Scan FSM; each compare is registered and acted on one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_vec       <= '0;
         r_idx       <= '0;
         r_chk_vld   <= 1'b0;
         r_chk_hit   <= 1'b0;
         r_chk_idx   <= '0;
         r_rdy       <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_y     <= 1'b0;
         r_out_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_vec     <= in_vec;
                  r_idx     <= '0;
                  r_chk_vld <= 1'b0;
                  r_chk_hit <= 1'b0;
                  r_rdy     <= 1'b0;
                  r_state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_chk_vld <= 1'b1;
               r_chk_hit <= w_hit;
               r_chk_idx <= r_idx;
               // The index saturates on the last entry; it restarts only from IDLE
               if (r_idx != LAST_IDX) begin
                  r_idx <= r_idx + IW'(1);
               end
               if (r_chk_vld && r_chk_hit) begin
                  r_out_valid <= 1'b1;
                  r_out_y     <= 1'b1;
                  r_out_idx   <= r_chk_idx;
                  r_state     <= ST_DONE;
               end else if (r_chk_vld && (r_chk_idx == LAST_IDX)) begin
                  r_out_valid <= 1'b1;
                  r_out_y     <= 1'b0;
                  r_out_idx   <= '0;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_rdy       <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_rdy       <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_rdy;
   assign cfg_ready = r_rdy;
   assign out_valid = r_out_valid;
   assign out_y     = r_out_y;
   assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_cube_eval_sched.sv
// Self-checking bench for cube_eval_sched: directed table, corner-case
// sequences and randomized vectors against a first-match reference model.
module tb_cube_eval_sched;
   import cube_pkg::*;

   localparam int NIN   = 14;
   localparam int NCUBE = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_we = 1'b0;
   logic [2:0]      cfg_idx = '0;
   logic            cfg_en = 1'b0;
   logic [NIN-1:0]  cfg_mask = '0;
   logic [NIN-1:0]  cfg_val = '0;
   logic            cfg_ready;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [NIN-1:0]  in_vec = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            out_y;
   logic [2:0]      out_idx;

   int n_tests = 0;
   int n_fail  = 0;

   cube_t m_tab [NCUBE];

   cube_eval_sched #(.NIN(NIN), .NCUBE(NCUBE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_en    (cfg_en),
      .cfg_mask  (cfg_mask),
      .cfg_val   (cfg_val),
      .cfg_ready (cfg_ready),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // First enabled cube whose cared literals agree wins; a miss costs a full table walk.
   function automatic void model(input logic [NIN-1:0] v, output logic y,
                                 output logic [2:0] idx, output int lat);
      y = 1'b0; idx = 3'd0; lat = NCUBE + 1;
      for (int k = NCUBE - 1; k >= 0; k--) begin
         if (m_tab[k].en && (((v ^ m_tab[k].val) & m_tab[k].mask) == 14'd0)) begin
            y = 1'b1; idx = 3'(k); lat = k + 2;
         end
      end
   endfunction

   task automatic cfg_write(input logic [2:0] idx, input logic en,
                            input logic [NIN-1:0] mask, input logic [NIN-1:0] val);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_mask = mask; cfg_val = val;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      m_tab[idx] = '{en: en, mask: mask, val: val};
   endtask

   task automatic wait_out(output logic y, output logic [2:0] idx, output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      y = out_y; idx = out_idx;
      if (!out_valid) lat = -1;
   endtask

   task automatic release_out(input int delay);
      repeat (delay) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input logic [NIN-1:0] v, input int delay,
                          output logic y, output logic [2:0] idx, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_vec = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(y, idx, lat);
      release_out(delay);
   endtask

   typedef struct {
      logic           do_cfg;
      logic [2:0]     c_idx;
      logic           c_en;
      logic [NIN-1:0] c_mask;
      logic [NIN-1:0] c_val;
      logic [NIN-1:0] vec;
      logic           exp_y;
      logic [2:0]     exp_idx;
      int             exp_lat;
   } row_t;

   row_t rows [5];

   initial begin
      logic           y;
      logic [2:0]     idx;
      int             lat;
      logic           my;
      logic [2:0]     midx;
      int             mlat;
      logic           seen;
      logic [NIN-1:0] v;

      rows[0] = '{1'b1, 3'd0, 1'b1, 14'h3FFF, 14'h3D25, 14'h3D25, 1'b1, 3'd0, 2};
      rows[1] = '{1'b0, 3'd0, 1'b0, 14'h0000, 14'h0000, 14'h3D24, 1'b0, 3'd0, 9};
      rows[2] = '{1'b1, 3'd3, 1'b1, 14'h0001, 14'h0001, 14'h0001, 1'b1, 3'd3, 5};
      rows[3] = '{1'b1, 3'd5, 1'b1, 14'h0000, 14'h0000, 14'h0000, 1'b1, 3'd5, 7};
      rows[4] = '{1'b0, 3'd0, 1'b0, 14'h0000, 14'h0000, 14'h0001, 1'b1, 3'd3, 5};
      for (int k = 0; k < NCUBE; k++) m_tab[k] = '{en: 1'b0, mask: 14'd0, val: 14'd0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_y", 32'(out_y), 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

      for (int r = 0; r < 5; r++) begin
         if (rows[r].do_cfg) cfg_write(rows[r].c_idx, rows[r].c_en, rows[r].c_mask, rows[r].c_val);
         run_vec(rows[r].vec, 0, y, idx, lat);
         check($sformatf("row%0d_y", r), 32'(y), 32'(rows[r].exp_y));
         check($sformatf("row%0d_idx", r), 32'(idx), 32'(rows[r].exp_idx));
         check($sformatf("row%0d_lat", r), 32'(lat), 32'(rows[r].exp_lat));
      end

      // Stalled consumer: outputs hold, input side closed, table write dropped
      @(negedge clk);
      in_valid = 1'b1; in_vec = 14'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(y, idx, lat);
      check("stall_first_idx", 32'(idx), 32'd3);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         cfg_we = (c == 0); cfg_idx = 3'd1; cfg_en = 1'b1; cfg_mask = 14'd0; cfg_val = 14'd0;
         @(posedge clk); #1;
         cfg_we = 1'b0;
         check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("stall%0d_y", c), 32'(out_y), 32'd1);
         check($sformatf("stall%0d_idx", c), 32'(out_idx), 32'd3);
         check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
         check($sformatf("stall%0d_cfg_ready", c), 32'(cfg_ready), 32'd0);
      end
      release_out(0);
      run_vec(14'h0000, 0, y, idx, lat);
      check("ignored_write_idx", 32'(idx), 32'd5);

      // Reset in the middle of a scan abandons the result and wipes the table
      @(negedge clk);
      in_valid = 1'b1; in_vec = 14'h3D24;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < NCUBE; k++) m_tab[k] = '{en: 1'b0, mask: 14'd0, val: 14'd0};
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      run_vec(14'h0000, 0, y, idx, lat);
      check("midrst_y", 32'(y), 32'd0);
      check("midrst_idx", 32'(idx), 32'd0);
      check("midrst_lat", 32'(lat), 32'd9);

      // Write coinciding with accept lands before the scan reads the table
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 3'd7; cfg_en = 1'b1; cfg_mask = 14'd0; cfg_val = 14'd0;
      in_valid = 1'b1; in_vec = 14'h3D24;
      @(posedge clk); #1;
      cfg_we = 1'b0; in_valid = 1'b0;
      m_tab[7] = '{en: 1'b1, mask: 14'd0, val: 14'd0};
      wait_out(y, idx, lat);
      release_out(0);
      check("coinc_y", 32'(y), 32'd1);
      check("coinc_idx", 32'(idx), 32'd7);
      check("coinc_lat", 32'(lat), 32'd9);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            cfg_write(3'($urandom_range(0, NCUBE - 1)), ($urandom_range(0, 3) != 0),
                      14'($urandom & $urandom & $urandom), 14'($urandom));
         end
         v = 14'($urandom);
         if ($urandom_range(0, 1) == 1) v = m_tab[$urandom_range(0, NCUBE - 1)].val ^ (v & 14'h0300);
         model(v, my, midx, mlat);
         run_vec(v, $urandom_range(0, 3), y, idx, lat);
         check($sformatf("rnd%0d_y", it), 32'(y), 32'(my));
         check($sformatf("rnd%0d_idx", it), 32'(idx), 32'(midx));
         check($sformatf("rnd%0d_lat", it), 32'(lat), 32'(mlat));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
